matrix_scan_pwm: RTL and testbench

Parametrised row-scanning driver for a bicolour (red/green) LED dot matrix with per-pixel PWM brightness. It replaces the 1-bit 8×8 scanner. It adds configurable geometry, multi-level brightness, inter-row blanking against ghosting, and a double-buffered frame load that swaps only at frame boundaries, so frames never tear. It sits between the display-content logic, which supplies a packed frame, and the matrix pins.

---
 rtl/matrix_pkg.sv | 30 +++
 rtl/matrix_row_decoder.sv | 24 ++
 rtl/matrix_scan_pwm.sv | 166 ++++++++++++++++
 tb/tb_matrix_scan_pwm.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared types and helpers for the bicolour LED matrix PWM scanner.
package matrix_pkg;

    typedef enum logic {
        S_SHOW  = 1'b0,
        S_BLANK = 1'b1
    } scan_state_e;

    // Ceiling log2; clog2(1) == 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = unsigned'(i) + 1;
            end
        end
        return r;
    endfunction

    // Bit offset of pixel (r,c) in the packed frame; row 0 sits at the MSB end.
    function automatic int unsigned pixel_base(input int unsigned rows,
                                               input int unsigned cols,
                                               input int unsigned bits,
                                               input int unsigned r,
                                               input int unsigned c);
        return ((rows - 1 - r) * cols + c) * 2 * bits;
    endfunction

endpackage

// File: rtl/matrix_row_decoder.sv
// Row index to one-hot active-low select; all ones when disabled.
module matrix_row_decoder
    import matrix_pkg::*;
#(
    parameter  int unsigned ROWS = 8,
    localparam int unsigned RW   = clog2(ROWS)
) (
    input  logic [RW-1:0]   row_i,
    input  logic            en_i,
    output logic [ROWS-1:0] sel_c_o
);

    always_comb begin
        sel_c_o = '1;
        if (en_i) begin
            for (int r = 0; r < ROWS; r++) begin
                if (row_i == RW'(r)) begin
                    sel_c_o[r] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/matrix_scan_pwm.sv
// Row-scanning bicolour LED matrix driver with per-pixel PWM, inter-row
// blanking and a double-buffered frame that swaps only at frame wrap.
module matrix_scan_pwm
    import matrix_pkg::*;
#(
    parameter int unsigned ROWS     = 8,
    parameter int unsigned COLS     = 8,
    parameter int unsigned BITS     = 2,
    parameter int unsigned TICK_DIV = 64,
    parameter int unsigned BLANK    = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ROWS*COLS*2*BITS-1:0] data,
    input  logic                       load,
    output logic                       frame_done,
    output logic [ROWS-1:0]            rowO,
    output logic [COLS-1:0]            colR,
    output logic [COLS-1:0]            colG
);

    localparam int unsigned FW         = ROWS * COLS * 2 * BITS;
    localparam int unsigned IW         = clog2(FW);
    localparam int unsigned L          = (1 << BITS) - 1;
    localparam int unsigned CW         = (TICK_DIV > 1) ? clog2(TICK_DIV) : 1;
    localparam int unsigned RW         = clog2(ROWS);
    localparam int unsigned PW         = (L > 1) ? clog2(L) : 1;
    localparam int unsigned BW         = (BLANK > 1) ? clog2(BLANK) : 1;
    localparam int unsigned BLANK_LAST = (BLANK > 0) ? BLANK - 1 : 0;

    logic [CW-1:0]   cnt_q,     cnt_d;
    scan_state_e     state_q,   state_d;
    logic [RW-1:0]   row_q,     row_d;
    logic [PW-1:0]   phase_q,   phase_d;
    logic [BW-1:0]   blank_q,   blank_d;
    logic [FW-1:0]   shadow_q,  shadow_d;
    logic [FW-1:0]   active_q,  active_d;
    logic            pending_q, pending_d;
    logic [ROWS-1:0] rowO_q,    rowO_d;
    logic [COLS-1:0] colR_q,    colR_d;
    logic [COLS-1:0] colG_q,    colG_d;
    logic            fd_q,      fd_d;

    logic            tick_c;
    logic            row_end_c;
    logic            wrap_c;
    logic [ROWS-1:0] row_sel_c;
    logic [IW-1:0]   rbase_c;
    logic [IW-1:0]   gbase_c;
    logic [BITS-1:0] red_c;
    logic [BITS-1:0] green_c;

    matrix_row_decoder #(
        .ROWS (ROWS)
    ) u_row_dec (
        .row_i   (row_q),
        .en_i    (state_q == S_SHOW),
        .sel_c_o (row_sel_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            state_q   <= S_SHOW;
            row_q     <= '0;
            phase_q   <= '0;
            blank_q   <= '0;
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            rowO_q    <= '1;
            colR_q    <= '0;
            colG_q    <= '0;
            fd_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            row_q     <= row_d;
            phase_q   <= phase_d;
            blank_q   <= blank_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            rowO_q    <= rowO_d;
            colR_q    <= colR_d;
            colG_q    <= colG_d;
            fd_q      <= fd_d;
        end
    end

    // Prescaler, scan FSM and frame-wrap detection.
    always_comb begin
        tick_c    = (cnt_q == CW'(TICK_DIV - 1));
        cnt_d     = tick_c ? '0 : cnt_q + CW'(1);
        state_d   = state_q;
        row_d     = row_q;
        phase_d   = phase_q;
        blank_d   = blank_q;
        row_end_c = 1'b0;

        if (tick_c) begin
            case (state_q)
                S_SHOW: begin
                    if (phase_q == PW'(L - 1)) begin
                        phase_d = '0;
                        if (BLANK == 0) begin
                            row_end_c = 1'b1;
                        end else begin
                            state_d = S_BLANK;
                            blank_d = '0;
                        end
                    end else begin
                        phase_d = phase_q + PW'(1);
                    end
                end
                S_BLANK: begin
                    if (blank_q == BW'(BLANK_LAST)) begin
                        row_end_c = 1'b1;
                        state_d   = S_SHOW;
                    end else begin
                        blank_d = blank_q + BW'(1);
                    end
                end
                default: state_d = S_SHOW;
            endcase
        end

        if (row_end_c) begin
            row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
        end
        wrap_c = row_end_c && (row_q == RW'(ROWS - 1));
    end

    // Shadow/active buffering: a load coinciding with the wrap keeps pending set.
    always_comb begin
        shadow_d  = load ? data : shadow_q;
        pending_d = load ? 1'b1 : (wrap_c ? 1'b0 : pending_q);
        active_d  = (wrap_c && pending_q) ? shadow_q : active_q;
        fd_d      = wrap_c;
    end

    // PWM comparators against the active buffer for the current row.
    always_comb begin
        rowO_d  = row_sel_c;
        colR_d  = '0;
        colG_d  = '0;
        rbase_c = '0;
        gbase_c = '0;
        red_c   = '0;
        green_c = '0;
        for (int c = 0; c < COLS; c++) begin
            rbase_c   = IW'(pixel_base(ROWS, COLS, BITS, 32'(row_q), unsigned'(c)));
            gbase_c   = IW'(pixel_base(ROWS, COLS, BITS, 32'(row_q), unsigned'(c)) + BITS);
            red_c     = active_q[rbase_c +: BITS];
            green_c   = active_q[gbase_c +: BITS];
            colR_d[c] = (state_q == S_SHOW) && (red_c   > BITS'(phase_q));
            colG_d[c] = (state_q == S_SHOW) && (green_c > BITS'(phase_q));
        end
    end

    assign frame_done = fd_q;
    assign rowO       = rowO_q;
    assign colR       = colR_q;
    assign colG       = colG_q;

endmodule

// File: tb/tb_matrix_scan_pwm.sv
// Directed bench for matrix_scan_pwm with TICK_DIV=4 (16 clk rows, 128 clk frames).
module tb_matrix_scan_pwm;

    localparam int unsigned FW = 8 * 8 * 2 * 2;

    logic          clk;
    logic          rst;
    logic [FW-1:0] data;
    logic          load;
    logic          frame_done;
    logic [7:0]    rowO;
    logic [7:0]    colR;
    logic [7:0]    colG;

    int checks   = 0;
    int failures = 0;
    int k        = -100;
    int fd_cnt   = 0;

    logic [FW-1:0] frm;

    matrix_scan_pwm #(
        .ROWS     (8),
        .COLS     (8),
        .BITS     (2),
        .TICK_DIV (4),
        .BLANK    (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .load       (load),
        .frame_done (frame_done),
        .rowO       (rowO),
        .colR       (colR),
        .colG       (colG)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] erow,
                           input logic [7:0] er, input logic [7:0] eg);
        chk({tag, ".rowO"}, 32'(rowO), 32'(erow));
        chk({tag, ".colR"}, 32'(colR), 32'(er));
        chk({tag, ".colG"}, 32'(colG), 32'(eg));
    endtask

    // Edge k of the run is sampled 1 ns after it; output at edge k shows slot k/4.
    task automatic step();
        @(posedge clk);
        #1;
        k++;
        if (frame_done === 1'b1) fd_cnt++;
    endtask

    task automatic run_to(input int target);
        while (k < target) step();
    endtask

    task automatic load_at(input int target, input logic [FW-1:0] value);
        run_to(target - 1);
        data = value;
        load = 1'b1;
        step();
        load = 1'b0;
        data = '0;
    endtask

    initial begin
        rst  = 1'b1;
        load = 1'b0;
        data = '0;

        repeat (3) step();
        chk_out("in_reset", 8'hFF, 8'h00, 8'h00);
        chk("in_reset.fd", 32'(frame_done), 32'd0);

        rst = 1'b0;
        k   = -1;
        step();
        chk_out("rel", 8'hFE, 8'h00, 8'h00);
        chk("rel.fd", 32'(frame_done), 32'd0);
        run_to(11);
        chk_out("row0_last_show", 8'hFE, 8'h00, 8'h00);
        run_to(12);
        chk_out("row0_blank", 8'hFF, 8'h00, 8'h00);
        run_to(16);
        chk_out("row1", 8'hFD, 8'h00, 8'h00);

        // Pixel (0,0): red=1, green=3 at base 224.
        frm = '0;
        frm[225:224] = 2'd1;
        frm[227:226] = 2'd3;
        load_at(20, frm);
        run_to(100);
        chk_out("pre_swap", 8'hBF, 8'h00, 8'h00);
        run_to(126);
        chk("fd_before", 32'(frame_done), 32'd0);
        run_to(127);
        chk("fd_wrap0", 32'(frame_done), 32'd1);
        run_to(128);
        chk("fd_after", 32'(frame_done), 32'd0);
        chk_out("bright_p0", 8'hFE, 8'h01, 8'h01);
        run_to(131);
        chk_out("bright_p0_end", 8'hFE, 8'h01, 8'h01);
        run_to(132);
        chk_out("bright_p1", 8'hFE, 8'h00, 8'h01);
        run_to(139);
        chk_out("bright_p2", 8'hFE, 8'h00, 8'h01);
        run_to(140);
        chk_out("bright_blank", 8'hFF, 8'h00, 8'h00);
        run_to(143);
        chk_out("bright_blank_end", 8'hFF, 8'h00, 8'h00);
        run_to(144);
        chk_out("bright_row1", 8'hFD, 8'h00, 8'h00);

        // Frame A all red=3, frame B all green=3; B loaded mid-frame.
        load_at(150, {64{4'h3}});
        run_to(256);
        chk_out("frameA_row0", 8'hFE, 8'hFF, 8'h00);
        fd_cnt = 0;
        load_at(300, {64{4'hC}});
        run_to(296);
        run_to(376);
        chk_out("frameA_row7", 8'h7F, 8'hFF, 8'h00);
        run_to(380);
        chk_out("frameA_row7_blank", 8'hFF, 8'h00, 8'h00);
        run_to(383);
        chk("fd_wrap2", 32'(frame_done), 32'd1);
        chk("fd_count_frame2", 32'(fd_cnt), 32'd1);
        run_to(384);
        chk_out("frameB_row0", 8'hFE, 8'h00, 8'hFF);
        run_to(396);
        chk_out("frameB_blank", 8'hFF, 8'h00, 8'h00);
        run_to(400);
        chk_out("frameB_row1", 8'hFD, 8'h00, 8'hFF);

        // D (red1 green2) pending, then E (red2 green1) strobed on the wrap edge.
        load_at(450, {64{4'h9}});
        load_at(511, {64{4'h6}});
        chk("fd_wrap3", 32'(frame_done), 32'd1);
        run_to(512);
        chk_out("frameD_p0", 8'hFE, 8'hFF, 8'hFF);
        run_to(516);
        chk_out("frameD_p1", 8'hFE, 8'h00, 8'hFF);
        run_to(639);
        chk("fd_wrap4", 32'(frame_done), 32'd1);
        run_to(644);
        chk_out("frameE_p1", 8'hFE, 8'hFF, 8'h00);
        run_to(648);
        chk_out("frameE_p2", 8'hFE, 8'h00, 8'h00);

        // Pending all-on frame discarded by reset in row 5.
        load_at(700, {64{4'hF}});
        run_to(724);
        chk_out("row5_pre_rst", 8'hDF, 8'hFF, 8'h00);
        rst = 1'b1;
        step();
        chk_out("mid_rst", 8'hFF, 8'h00, 8'h00);
        chk("mid_rst.fd", 32'(frame_done), 32'd0);
        rst = 1'b0;
        k   = -1;
        step();
        chk_out("rel2", 8'hFE, 8'h00, 8'h00);
        run_to(127);
        chk("fd_after_rst", 32'(frame_done), 32'd1);
        run_to(128);
        chk_out("dark_p0", 8'hFE, 8'h00, 8'h00);
        run_to(132);
        chk_out("dark_p1", 8'hFE, 8'h00, 8'h00);
        run_to(212);
        chk_out("dark_row5", 8'hDF, 8'h00, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
